// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front-end.
// Provides the core's menu/state encoding, keypad command codes, per-field
// numeric limits and the keypad FSM state type.
package atm_pkg;

  // Core menu/state encoding driven on menuOption
  localparam logic [2:0] WAITING               = 3'd0;
  localparam logic [2:0] GET_PIN               = 3'd1;
  localparam logic [2:0] MENU                  = 3'd2;
  localparam logic [2:0] BALANCE               = 3'd3;
  localparam logic [2:0] WITHDRAW              = 3'd4;
  localparam logic [2:0] WITHDRAW_SHOW_BALANCE = 3'd5;
  localparam logic [2:0] TRANSACTION           = 3'd6;
  localparam logic [2:0] DONE                  = 3'd7;

  // Keypad command codes (0-9 are digits, D-F are ignored)
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Field limits: largest accepted value and number of digits
  localparam int ACC_MAX     = 4095;
  localparam int PIN_MAX     = 15;
  localparam int AMT_MAX     = 2047;
  localparam int MENU_MAX    = 9;
  localparam int ACC_DIGITS  = 4;
  localparam int PIN_DIGITS  = 2;
  localparam int AMT_DIGITS  = 4;
  localparam int MENU_DIGITS = 1;

  typedef enum logic [2:0] {
    S_ACC  = 3'd0,
    S_PIN  = 3'd1,
    S_MENU = 3'd2,
    S_DEST = 3'd3,
    S_AMT  = 3'd4
  } state_e;

  // Menu digits the core understands
  function automatic logic is_menu_code(input logic [3:0] d);
    return (d >= 4'd3) && (d <= 4'd6);
  endfunction

endpackage

// File: rtl/atm_keypad_entry_dec_accum.sv
// dec_accum: decimal entry accumulator for one operand field.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - append digit (ignored when reject is high)
//   clear     - zero the value and the digit count (wins over load)
//   digit     - decimal digit 0-9
//   value     - accumulated binary value
//   empty     - no digit entered yet
//   reject    - the current digit would overflow the field; independent of
//               load so the caller can use it without a combinational loop
module dec_accum #(
  parameter int MAX        = 4095,
  parameter int MAX_DIGITS = 4,
  parameter int WIDTH      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value,
  output logic             empty,
  output logic             reject
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [WIDTH-1:0] val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [13:0]      buf_next;

  // 14 bits is enough: the count limit stops any field before its product
  // could wrap, and a full field is rejected regardless of buf_next.
  always_comb begin
    buf_next = 14'(val_q) * 14'd10 + 14'(digit);
    reject   = (cnt_q == CNT_W'(MAX_DIGITS)) || (buf_next > 14'(MAX));
    val_d    = val_q;
    cnt_d    = cnt_q;
    if (clear) begin
      val_d = '0;
      cnt_d = '0;
    end else if (load && !reject) begin
      val_d = buf_next[WIDTH-1:0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign value = val_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front-end for the ATM core.
// Collects decimal keys per field, latches the core operand bus and issues
// one cmd_strobe per completed transaction; generates exit on CANCEL or idle
// timeout.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   key_valid, key_code  - one-cycle key event (0-9, A=ENTER, B=CLEAR, C=CANCEL)
//   accNumber, pin       - latched login operands
//   menuOption, amount, destinationAccNumber - latched transaction operands
//   cmd_strobe, exit, entry_error, timeout   - one-cycle status pulses
//   state_dbg            - current FSM state
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] accNumber,
  output logic [3:0]  pin,
  output logic [2:0]  menuOption,
  output logic [10:0] amount,
  output logic [11:0] destinationAccNumber,
  output logic        cmd_strobe,
  output logic        exit,
  output logic        entry_error,
  output logic        timeout,
  output logic [2:0]  state_dbg
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [11:0] acc_number_q, acc_number_d;
  logic [3:0]  pin_q, pin_d;
  logic [2:0]  menu_option_q, menu_option_d;
  logic [10:0] amount_q, amount_d;
  logic [11:0] dest_q, dest_d;
  logic        cmd_strobe_q, cmd_strobe_d;
  logic        exit_q, exit_d;
  logic        entry_error_q, entry_error_d;
  logic        timeout_q, timeout_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic ld_acc, ld_pin, ld_menu, ld_dest, ld_amt;
  logic clr_acc, clr_pin, clr_menu, clr_dest, clr_amt;
  logic [11:0] acc_val, dest_val;
  logic [3:0]  pin_val, menu_val;
  logic [10:0] amt_val;
  logic acc_empty, pin_empty, menu_empty, dest_empty, amt_empty;
  logic rej_acc, rej_pin, rej_menu, rej_dest, rej_amt;
  logic is_digit, is_enter, is_clear, is_cancel;
  logic idle_hold, timeout_hit, do_cancel, cur_empty;

  dec_accum #(.MAX(ACC_MAX), .MAX_DIGITS(ACC_DIGITS), .WIDTH(12)) u_acc (
    .clk(clk), .rst(rst), .load(ld_acc), .clear(clr_acc), .digit(key_code),
    .value(acc_val), .empty(acc_empty), .reject(rej_acc));
  dec_accum #(.MAX(PIN_MAX), .MAX_DIGITS(PIN_DIGITS), .WIDTH(4)) u_pin (
    .clk(clk), .rst(rst), .load(ld_pin), .clear(clr_pin), .digit(key_code),
    .value(pin_val), .empty(pin_empty), .reject(rej_pin));
  dec_accum #(.MAX(MENU_MAX), .MAX_DIGITS(MENU_DIGITS), .WIDTH(4)) u_menu (
    .clk(clk), .rst(rst), .load(ld_menu), .clear(clr_menu), .digit(key_code),
    .value(menu_val), .empty(menu_empty), .reject(rej_menu));
  dec_accum #(.MAX(ACC_MAX), .MAX_DIGITS(ACC_DIGITS), .WIDTH(12)) u_dest (
    .clk(clk), .rst(rst), .load(ld_dest), .clear(clr_dest), .digit(key_code),
    .value(dest_val), .empty(dest_empty), .reject(rej_dest));
  dec_accum #(.MAX(AMT_MAX), .MAX_DIGITS(AMT_DIGITS), .WIDTH(11)) u_amt (
    .clk(clk), .rst(rst), .load(ld_amt), .clear(clr_amt), .digit(key_code),
    .value(amt_val), .empty(amt_empty), .reject(rej_amt));

  // Key decode and inactivity timer. The timer reads 1 in the cycle after a
  // key, so the terminal value TIMEOUT_CYCLES-1 falls TIMEOUT_CYCLES-1 cycles
  // after the key and exit lands TIMEOUT_CYCLES cycles after it. An empty
  // login screen is not a session, so the timer is parked there.
  always_comb begin
    is_digit    = key_valid && (key_code <= 4'd9);
    is_enter    = key_valid && (key_code == KEY_ENTER);
    is_clear    = key_valid && (key_code == KEY_CLEAR);
    is_cancel   = key_valid && (key_code == KEY_CANCEL);
    idle_hold   = (state_q == S_ACC) && acc_empty;
    timeout_hit = !key_valid && !idle_hold &&
                  (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    do_cancel   = is_cancel || timeout_hit;
    if (key_valid)                   timer_d = TMR_W'(1);
    else if (idle_hold || timeout_hit) timer_d = '0;
    else                             timer_d = timer_q + TMR_W'(1);
    case (state_q)
      S_ACC:   cur_empty = acc_empty;
      S_PIN:   cur_empty = pin_empty;
      S_MENU:  cur_empty = menu_empty;
      S_DEST:  cur_empty = dest_empty;
      S_AMT:   cur_empty = amt_empty;
      default: cur_empty = 1'b1;
    endcase
  end

  // Next-state, operand latching and field buffer control
  always_comb begin
    state_d       = state_q;
    acc_number_d  = acc_number_q;
    pin_d         = pin_q;
    menu_option_d = menu_option_q;
    amount_d      = amount_q;
    dest_d        = dest_q;
    cmd_strobe_d  = 1'b0;
    exit_d        = 1'b0;
    entry_error_d = 1'b0;
    timeout_d     = 1'b0;
    {ld_acc, ld_pin, ld_menu, ld_dest, ld_amt}      = '0;
    {clr_acc, clr_pin, clr_menu, clr_dest, clr_amt} = '0;

    if (do_cancel) begin
      {clr_acc, clr_pin, clr_menu, clr_dest, clr_amt} = '1;
      acc_number_d  = '0;
      pin_d         = '0;
      menu_option_d = WAITING;
      amount_d      = '0;
      dest_d        = '0;
      exit_d        = 1'b1;
      timeout_d     = timeout_hit;
      state_d       = S_ACC;
    end else if (is_digit) begin
      case (state_q)
        S_ACC:  begin ld_acc  = 1'b1; entry_error_d = rej_acc;  end
        S_PIN:  begin ld_pin  = 1'b1; entry_error_d = rej_pin;  end
        S_DEST: begin ld_dest = 1'b1; entry_error_d = rej_dest; end
        S_AMT:  begin ld_amt  = 1'b1; entry_error_d = rej_amt;  end
        S_MENU: begin
          if (is_menu_code(key_code)) begin
            ld_menu       = 1'b1;
            entry_error_d = rej_menu;
          end else begin
            entry_error_d = 1'b1;
          end
        end
        default: entry_error_d = 1'b1;
      endcase
    end else if (is_clear) begin
      case (state_q)
        S_ACC:   clr_acc  = 1'b1;
        S_PIN:   clr_pin  = 1'b1;
        S_MENU:  clr_menu = 1'b1;
        S_DEST:  clr_dest = 1'b1;
        S_AMT:   clr_amt  = 1'b1;
        default: ;
      endcase
    end else if (is_enter) begin
      if (cur_empty) begin
        entry_error_d = 1'b1;
      end else begin
        case (state_q)
          S_ACC: state_d = S_PIN;
          S_PIN: begin
            acc_number_d = acc_val;
            pin_d        = pin_val;
            state_d      = S_MENU;
          end
          S_MENU: begin
            case (menu_val)
              4'd3: begin
                // Balance needs no operands; amount and dest keep last values
                menu_option_d = BALANCE;
                cmd_strobe_d  = 1'b1;
                {clr_menu, clr_dest, clr_amt} = '1;
              end
              4'd4, 4'd5: state_d = S_AMT;
              4'd6:       state_d = S_DEST;
              default:    entry_error_d = 1'b1;
            endcase
          end
          S_DEST: state_d = S_AMT;
          S_AMT: begin
            // dest buffer is still clear for withdrawals, so dest reads 0
            menu_option_d = menu_val[2:0];
            amount_d      = amt_val;
            dest_d        = dest_val;
            cmd_strobe_d  = 1'b1;
            {clr_menu, clr_dest, clr_amt} = '1;
            state_d       = S_MENU;
          end
          default: state_d = S_ACC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ACC;
      acc_number_q  <= '0;
      pin_q         <= '0;
      menu_option_q <= WAITING;
      amount_q      <= '0;
      dest_q        <= '0;
      cmd_strobe_q  <= 1'b0;
      exit_q        <= 1'b0;
      entry_error_q <= 1'b0;
      timeout_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      acc_number_q  <= acc_number_d;
      pin_q         <= pin_d;
      menu_option_q <= menu_option_d;
      amount_q      <= amount_d;
      dest_q        <= dest_d;
      cmd_strobe_q  <= cmd_strobe_d;
      exit_q        <= exit_d;
      entry_error_q <= entry_error_d;
      timeout_q     <= timeout_d;
      timer_q       <= timer_d;
    end
  end

  assign accNumber            = acc_number_q;
  assign pin                  = pin_q;
  assign menuOption           = menu_option_q;
  assign amount               = amount_q;
  assign destinationAccNumber = dest_q;
  assign cmd_strobe           = cmd_strobe_q;
  assign exit                 = exit_q;
  assign entry_error          = entry_error_q;
  assign timeout              = timeout_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Testbench for atm_keypad_entry: table of key events with expected outputs,
// followed by hand-written timeout and mid-entry reset sequences.
module tb_atm_keypad_entry;

  localparam logic [3:0] ENT = 4'hA;
  localparam logic [3:0] CLR = 4'hB;
  localparam logic [3:0] CAN = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] accNumber;
  logic [3:0]  pin;
  logic [2:0]  menuOption;
  logic [10:0] amount;
  logic [11:0] destinationAccNumber;
  logic        cmd_strobe;
  logic        exit;
  logic        entry_error;
  logic        timeout;
  logic [2:0]  state_dbg;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic [11:0] acc;
    logic [3:0]  pin;
    logic [2:0]  menu;
    logic [10:0] amt;
    logic [11:0] dest;
    logic        cmd;
    logic        ex;
    logic        err;
    logic        to;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  atm_keypad_entry #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .accNumber(accNumber), .pin(pin), .menuOption(menuOption),
    .amount(amount), .destinationAccNumber(destinationAccNumber),
    .cmd_strobe(cmd_strobe), .exit(exit), .entry_error(entry_error),
    .timeout(timeout), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] code,
                              input int acc, input int p, input int menu,
                              input int amt, input int dest, input logic cmd,
                              input logic ex, input logic err, input logic to,
                              input int st);
    vec_t r;
    r.v = v; r.code = code; r.acc = 12'(acc); r.pin = 4'(p);
    r.menu = 3'(menu); r.amt = 11'(amt); r.dest = 12'(dest);
    r.cmd = cmd; r.ex = ex; r.err = err; r.to = to; r.st = 3'(st);
    return r;
  endfunction

  // Present one key (or idle cycle) and return 1ns after the sampling edge
  task automatic applyStimulus(input logic v, input logic [3:0] c);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s #%0d %s: got %0d expected %0d", tag, idx, name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int idx, input vec_t e);
    checkOutput(tag, idx, "accNumber", 32'(accNumber), 32'(e.acc));
    checkOutput(tag, idx, "pin", 32'(pin), 32'(e.pin));
    checkOutput(tag, idx, "menuOption", 32'(menuOption), 32'(e.menu));
    checkOutput(tag, idx, "amount", 32'(amount), 32'(e.amt));
    checkOutput(tag, idx, "dest", 32'(destinationAccNumber), 32'(e.dest));
    checkOutput(tag, idx, "cmd_strobe", 32'(cmd_strobe), 32'(e.cmd));
    checkOutput(tag, idx, "exit", 32'(exit), 32'(e.ex));
    checkOutput(tag, idx, "entry_error", 32'(entry_error), 32'(e.err));
    checkOutput(tag, idx, "timeout", 32'(timeout), 32'(e.to));
    checkOutput(tag, idx, "state", 32'(state_dbg), 32'(e.st));
  endtask

  initial begin
    logic saw_exit;

    // Login
    vecs.push_back(mk(1, 4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, ENT,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, ENT,  2178, 4, 0, 0, 0, 0, 0, 0, 0, 2));
    // Withdraw-show-balance of 100
    vecs.push_back(mk(1, 4'd5, 2178, 4, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, ENT,  2178, 4, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd1, 2178, 4, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd0, 2178, 4, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd0, 2178, 4, 0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, ENT,  2178, 4, 5, 100, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 4'd0, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 2));
    // Transfer 50 to 2816
    vecs.push_back(mk(1, 4'd6, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, ENT,  2178, 4, 5, 100, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4'd2, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4'd8, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4'd1, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4'd6, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, ENT,  2178, 4, 5, 100, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd5, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd0, 2178, 4, 5, 100, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, ENT,  2178, 4, 6, 50, 2816, 1, 0, 0, 0, 2));
    // Menu error, clear, empty enter, then balance keeps amount/dest
    vecs.push_back(mk(1, 4'd7, 2178, 4, 6, 50, 2816, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 4'd3, 2178, 4, 6, 50, 2816, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, CLR,  2178, 4, 6, 50, 2816, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, ENT,  2178, 4, 6, 50, 2816, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 4'd3, 2178, 4, 6, 50, 2816, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, ENT,  2178, 4, 3, 50, 2816, 1, 0, 0, 0, 2));
    // Withdraw with amount overflow: 2550 > 2047 rejected, 255 issued
    vecs.push_back(mk(1, 4'd4, 2178, 4, 3, 50, 2816, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, ENT,  2178, 4, 3, 50, 2816, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd2, 2178, 4, 3, 50, 2816, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd5, 2178, 4, 3, 50, 2816, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd5, 2178, 4, 3, 50, 2816, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4'd0, 2178, 4, 3, 50, 2816, 0, 0, 1, 0, 4));
    vecs.push_back(mk(1, ENT,  2178, 4, 4, 255, 0, 1, 0, 0, 0, 2));
    // Ignored code, cancel, cancel on empty login
    vecs.push_back(mk(1, 4'hD, 2178, 4, 4, 255, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, CAN,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, CAN,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // PIN limits: 16 too large, 15 accepted, third digit rejected
    vecs.push_back(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, ENT,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 4'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, ENT,  1, 15, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, CAN,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    idleCycles(2);
    rst = 1'b0;
    checkAll("reset", 0, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Empty login screen must never time out
    saw_exit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idleCycles(1);
      if (exit === 1'b1 || timeout === 1'b1) saw_exit = 1'b1;
    end
    checkOutput("idle_hold", 0, "exit_seen", 32'(saw_exit), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].v, vecs[i].code);
      checkAll("vec", i, vecs[i]);
    end

    // Timeout: exit and timeout 16 cycles after the last key
    applyStimulus(1'b1, 4'd9);
    idleCycles(14);
    checkOutput("to_a", 0, "exit_early", 32'(exit), 32'd0);
    idleCycles(1);
    checkAll("to_a", 1, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    idleCycles(1);
    checkAll("to_a", 2, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b1, ENT);
    checkOutput("to_a", 3, "buffer_cleared_err", 32'(entry_error), 32'd1);

    // A key in the terminal timer cycle wins and restarts the timer
    applyStimulus(1'b1, 4'd9);
    idleCycles(14);
    applyStimulus(1'b1, 4'd8);
    checkAll("to_b", 0, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idleCycles(14);
    checkOutput("to_b", 1, "exit_early", 32'(exit), 32'd0);
    idleCycles(1);
    checkAll("to_b", 2, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));

    // Mid-entry reset: silent, and the partial field is discarded
    applyStimulus(1'b1, 4'd1);
    applyStimulus(1'b1, 4'd2);
    applyStimulus(1'b1, ENT);
    checkOutput("rst_mid", 0, "state", 32'(state_dbg), 32'd1);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    checkAll("rst_mid", 1, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1'b1, ENT);
    checkAll("rst_mid", 2, mk(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
